// File: rtl/keypad_bcd_entry_if.sv
// keypad_bcd_entry_if: keypad scan lines and BCD entry outputs of keypad_bcd_entry
interface keypad_bcd_entry_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       key_valid;
    logic [3:0] key_code;
    logic       entry_done;
    logic       entry_err;
    modport master (
        input  row_in,
        output col_out, digit2, digit1, digit0, key_valid, key_code, entry_done, entry_err
    );
    modport slave (
        output row_in,
        input  col_out, digit2, digit1, digit0, key_valid, key_code, entry_done, entry_err
    );
endinterface

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry: scans a 4x4 keypad, debounces presses and builds a 3-digit BCD entry
module keypad_bcd_entry #(
    parameter int DIV_EXP = 17,
    parameter int DEB_CNT = 4,
    parameter int MAX_VAL = 321
) (
    input logic clk,
    input logic reset,
    keypad_bcd_entry_if.master kp
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam int CW = $clog2(DEB_CNT + 1);
    state_t state, state_nxt;
    logic [DIV_EXP-1:0] div_cnt;
    logic tick;
    logic [3:0] row_s1, row_s2;
    logic [1:0] col_idx, col_nxt, row_lat, row_nxt, low_idx;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic low_any, is_digit, reject;
    logic [3:0] key, r4, c4;
    logic [9:0] shv;
    assign kp.col_out = ~(4'b0001 << col_idx);
    assign low_any = ~&row_s2;
    assign low_idx = !row_s2[0] ? 2'd0 : !row_s2[1] ? 2'd1 : !row_s2[2] ? 2'd2 : 2'd3;
    assign cnt_inc = cnt + CW'(1);
    assign r4 = {2'b00, row_lat};
    assign c4 = {2'b00, col_idx};
    // column 3 holds A-D, row 3 holds * 0 #; the rest is a plain 1-9 grid
    assign key = c4 == 4'd3 ? 4'd10 + r4 :
                 r4 != 4'd3 ? r4 * 4'd3 + c4 + 4'd1 :
                 c4 == 4'd0 ? 4'd14 : c4 == 4'd1 ? 4'd0 : 4'd15;
    assign is_digit = key < 4'd10;
    assign shv = 10'(kp.digit1) * 10'd100 + 10'(kp.digit0) * 10'd10 + 10'(key);
    assign reject = kp.digit2 != 4'd0 || 32'(shv) > MAX_VAL;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            row_s1  <= '1;
            row_s2  <= '1;
            state   <= SCAN;
            col_idx <= '0;
            row_lat <= '0;
            cnt     <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_EXP'(1);
            tick    <= &div_cnt;
            row_s1  <= kp.row_in;
            row_s2  <= row_s1;
            state   <= state_nxt;
            col_idx <= col_nxt;
            row_lat <= row_nxt;
            cnt     <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        row_nxt   = row_lat;
        cnt_nxt   = cnt;
        if (state == PRESSED) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (low_any) begin
                        state_nxt = DEBOUNCE;
                        row_nxt   = low_idx;
                        cnt_nxt   = '0;
                    end else begin
                        col_nxt = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s2[row_lat]) begin
                        state_nxt = SCAN;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CW'(DEB_CNT - 1)) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                RELEASE: begin
                    if (low_any) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc == CW'(DEB_CNT)) begin
                        state_nxt = SCAN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
    // outputs register on the edge that leaves PRESSED, so digits and key_valid change together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kp.key_valid  <= 1'b0;
            kp.entry_err  <= 1'b0;
            kp.entry_done <= 1'b0;
            kp.key_code   <= '0;
            kp.digit2     <= '0;
            kp.digit1     <= '0;
            kp.digit0     <= '0;
        end else begin
            kp.key_valid <= state == PRESSED;
            kp.entry_err <= state == PRESSED && is_digit && reject;
            if (state == PRESSED) begin
                kp.key_code <= key;
                if (is_digit && !reject) begin
                    kp.digit2     <= kp.digit1;
                    kp.digit1     <= kp.digit0;
                    kp.digit0     <= key;
                    kp.entry_done <= 1'b0;
                end else if (key == 4'd14) begin
                    kp.digit2     <= '0;
                    kp.digit1     <= '0;
                    kp.digit0     <= '0;
                    kp.entry_done <= 1'b0;
                end else if (key == 4'd15) begin
                    kp.entry_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb_keypad_bcd_entry: directed keypad sequences with hand-computed results
module tb_keypad_bcd_entry;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] held = '0;
    int n_vec = 0;
    int n_bad = 0;
    int kv_cnt = 0;
    int err_cnt = 0;
    int k0, e0;
    // key code -> row*4+col position on the pad
    int kpos [16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 15, 12, 14};
    keypad_bcd_entry_if kif();
    keypad_bcd_entry #(.DIV_EXP(3), .DEB_CNT(4), .MAX_VAL(321)) dut (
        .clk(clk),
        .reset(reset),
        .kp(kif)
    );
    always #5 clk = ~clk;
    always_comb for (int r = 0; r < 4; r++) kif.row_in[r] = ~|(held[r*4 +: 4] & ~kif.col_out);
    always @(negedge clk) begin
        kv_cnt  <= kv_cnt + int'(kif.key_valid);
        err_cnt <= err_cnt + int'(kif.entry_err);
    end
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask
    function automatic int dig();
        return int'({kif.digit2, kif.digit1, kif.digit0});
    endfunction
    function automatic int flags();
        return int'({kif.key_valid, kif.entry_done, kif.entry_err});
    endfunction
    task automatic tick_wait(input int n);
        repeat (8 * n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask
    task automatic press(input int code, input int hold, input int rel);
        held = 16'(1) << kpos[code];
        tick_wait(hold);
        held = '0;
        tick_wait(rel);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", int'(kif.col_out), 'he);
        chk("rst_dig", dig(), 0);
        chk("rst_code", int'(kif.key_code), 0);
        chk("rst_flags", flags(), 0);
        do_reset();
        tick_wait(1);
        chk("scan_rot", int'(kif.col_out), 'hd);
        k0 = kv_cnt;
        press(3, 8, 8);
        press(2, 8, 8);
        press(1, 8, 8);
        press(15, 8, 8);
        chk("seq_kv", kv_cnt - k0, 4);
        chk("seq_dig", dig(), 'h321);
        chk("seq_done", int'(kif.entry_done), 1);
        chk("seq_code", int'(kif.key_code), 15);
        press(10, 8, 8);
        chk("a_code", int'(kif.key_code), 10);
        chk("a_dig", dig(), 'h321);
        chk("a_done", int'(kif.entry_done), 1);
        e0 = err_cnt;
        press(4, 8, 8);
        chk("full_err", err_cnt - e0, 1);
        chk("full_dig", dig(), 'h321);
        chk("full_code", int'(kif.key_code), 4);
        press(14, 8, 8);
        chk("star_dig", dig(), 0);
        chk("star_done", int'(kif.entry_done), 0);
        press(15, 8, 8);
        chk("hash_done", int'(kif.entry_done), 1);
        press(3, 8, 8);
        chk("digit_clr_done", int'(kif.entry_done), 0);
        press(2, 8, 8);
        chk("ent032", dig(), 'h032);
        e0 = err_cnt;
        k0 = kv_cnt;
        press(5, 8, 8);
        chk("over_err", err_cnt - e0, 1);
        chk("over_kv", kv_cnt - k0, 1);
        chk("over_dig", dig(), 'h032);
        press(14, 8, 8);
        chk("star2_dig", dig(), 0);
        chk("star2_done", int'(kif.entry_done), 0);
        do_reset();
        k0 = kv_cnt;
        held = 16'(1) << kpos[1];
        tick_wait(2);
        held = '0;
        tick_wait(1);
        held = 16'(1) << kpos[1];
        tick_wait(3);
        chk("bounce_early", kv_cnt - k0, 0);
        tick_wait(1);
        chk("bounce_kv", kv_cnt - k0, 1);
        tick_wait(1);
        held = '0;
        tick_wait(8);
        chk("bounce_once", kv_cnt - k0, 1);
        chk("bounce_code", int'(kif.key_code), 1);
        do_reset();
        k0 = kv_cnt;
        held = 16'(1) << kpos[7];
        tick_wait(50);
        chk("hold_kv", kv_cnt - k0, 1);
        chk("hold_code", int'(kif.key_code), 7);
        held = '0;
        tick_wait(1);
        held = 16'(1) << kpos[7];
        tick_wait(1);
        held = '0;
        tick_wait(4);
        chk("glitch_col_held", int'(kif.col_out), 'he);
        tick_wait(1);
        chk("glitch_col_rot", int'(kif.col_out), 'hd);
        chk("glitch_kv", kv_cnt - k0, 1);
        do_reset();
        press(1, 5, 4);
        held = 16'(1) << kpos[9];
        tick_wait(4);
        chk("deb_col", int'(kif.col_out), 'hb);
        reset = 1'b1;
        #1;
        chk("abort_col", int'(kif.col_out), 'he);
        chk("abort_dig", dig(), 0);
        chk("abort_code", int'(kif.key_code), 0);
        chk("abort_flags", flags(), 0);
        do_reset();
        k0 = kv_cnt;
        tick_wait(5);
        chk("abort_no_kv", kv_cnt - k0, 0);
        tick_wait(1);
        chk("abort_new_kv", kv_cnt - k0, 1);
        chk("abort_code9", int'(kif.key_code), 9);
        held = '0;
        tick_wait(8);
        k0 = kv_cnt;
        held = (16'(1) << kpos[4]) | (16'(1) << kpos[7]);
        tick_wait(8);
        held = '0;
        tick_wait(8);
        chk("multi_kv", kv_cnt - k0, 1);
        chk("multi_code", int'(kif.key_code), 4);
        chk("multi_dig", dig(), 'h094);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
